// File: rtl/game_state_ctrl.sv
// Game-flow controller: IDLE -> PLAY -> WIN/LOSE -> IDLE, with alien/life counters and score.
// Define GAME_SCORE_EN to compile in the saturating score accumulator; otherwise score is tied to zero.
module game_state_ctrl #(
   parameter int NUM_ALIENS       = 24,
   parameter int NUM_LIVES        = 3,
   parameter int HOLD_CYCLES      = 320_000_000,
   parameter int POINTS_PER_ALIEN = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_btn,
   input  logic        alien_hit,
   input  logic        player_hit,
   output logic        game_active,
   output logic        winner,
   output logic        game_over,
   output logic [5:0]  aliens_left,
   output logic [1:0]  lives_left,
   output logic [15:0] score
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [5:0]        ALIENS_INIT = 6'(NUM_ALIENS);
   localparam logic [1:0]        LIVES_INIT  = 2'(NUM_LIVES);

   typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

   state_t            state;
   logic              start_q;
   logic [HOLD_W-1:0] hold_cnt;
   logic              start_rise;

   // start_q resets high so a button held through reset does not start a game
   assign start_rise = start_btn & ~start_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         start_q     <= 1'b1;
         hold_cnt    <= '0;
         game_active <= 1'b0;
         winner      <= 1'b0;
         game_over   <= 1'b0;
         aliens_left <= '0;
         lives_left  <= '0;
      end else begin
         start_q <= start_btn;
         case (state)
            IDLE: begin
               if (start_rise) begin
                  state       <= PLAY;
                  game_active <= 1'b1;
                  aliens_left <= ALIENS_INIT;
                  lives_left  <= LIVES_INIT;
               end
            end
            PLAY: begin
               if (alien_hit && aliens_left != 6'd0)
                  aliens_left <= aliens_left - 6'd1;
               if (player_hit && lives_left != 2'd0)
                  lives_left <= lives_left - 2'd1;
               // a simultaneous last alien and last life counts as a win
               if (alien_hit && aliens_left == 6'd1) begin
                  state       <= WIN;
                  game_active <= 1'b0;
                  winner      <= 1'b1;
               end else if (player_hit && lives_left == 2'd1) begin
                  state       <= LOSE;
                  game_active <= 1'b0;
                  game_over   <= 1'b1;
               end
            end
            WIN, LOSE: begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_cnt  <= '0;
                  state     <= IDLE;
                  winner    <= 1'b0;
                  game_over <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef GAME_SCORE_EN
   function automatic logic [15:0] sat_add_points(input logic [15:0] value);
      logic [16:0] sum;
      sum = {1'b0, value} + 17'(POINTS_PER_ALIEN);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         score <= '0;
      end else if (state == IDLE && start_rise) begin
         score <= '0;
      end else if (state == PLAY && alien_hit && aliens_left != 6'd0) begin
         score <= sat_add_points(score);
      end
   end
`else
   // points value still referenced so both builds share one parameter list
   assign score = 16'(POINTS_PER_ALIEN) & 16'h0000;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with NUM_ALIENS=24, NUM_LIVES=3, HOLD_CYCLES=16.
module tb_game_state_ctrl;

   localparam int HOLD = 16;
`ifdef GAME_SCORE_EN
   localparam bit SCORE_EN = 1'b1;
`else
   localparam bit SCORE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_btn = 1'b0;
   logic        alien_hit = 1'b0;
   logic        player_hit = 1'b0;
   logic        game_active;
   logic        winner;
   logic        game_over;
   logic [5:0]  aliens_left;
   logic [1:0]  lives_left;
   logic [15:0] score;

   int total = 0;
   int bad = 0;

   game_state_ctrl #(
      .NUM_ALIENS(24), .NUM_LIVES(3), .HOLD_CYCLES(HOLD), .POINTS_PER_ALIEN(10)
   ) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn), .alien_hit(alien_hit),
      .player_hit(player_hit), .game_active(game_active), .winner(winner),
      .game_over(game_over), .aliens_left(aliens_left), .lives_left(lives_left),
      .score(score)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_score(input int v);
      return SCORE_EN ? 16'(v) : 16'h0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_start();
      start_btn = 1'b0;
      tick();
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      total++; if ({game_active, winner, game_over} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", {game_active, winner, game_over}); end
      total++; if ({aliens_left, lives_left, score} !== 24'h0) begin bad++; $display("FAIL reset_counts: got %h expected 000000", {aliens_left, lives_left, score}); end
      rst = 1'b0;
      press_start();
      total++; if (game_active !== 1'b1) begin bad++; $display("FAIL start_active: got %b expected 1", game_active); end
      total++; if (aliens_left !== 6'd24) begin bad++; $display("FAIL start_aliens: got %0d expected 24", aliens_left); end
      total++; if (lives_left !== 2'd3) begin bad++; $display("FAIL start_lives: got %0d expected 3", lives_left); end
      total++; if (score !== 16'd0) begin bad++; $display("FAIL start_score: got %0d expected 0", score); end
   endtask

   task automatic test_win();
      int cnt;
      alien_hit = 1'b1;
      repeat (24) tick();
      alien_hit = 1'b0;
      total++; if (winner !== 1'b1 || game_active !== 1'b0) begin bad++; $display("FAIL win_flags: got winner=%b active=%b expected 1/0", winner, game_active); end
      total++; if (aliens_left !== 6'd0) begin bad++; $display("FAIL win_aliens: got %0d expected 0", aliens_left); end
      total++; if (score !== exp_score(240)) begin bad++; $display("FAIL win_score: got %0d expected %0d", score, exp_score(240)); end
      cnt = 0;
      while (winner === 1'b1 && cnt < 40) begin
         cnt++;
         tick();
      end
      total++; if (cnt != HOLD) begin bad++; $display("FAIL win_hold_len: got %0d expected %0d", cnt, HOLD); end
      total++; if (winner !== 1'b0 || game_active !== 1'b0) begin bad++; $display("FAIL win_idle: got winner=%b active=%b expected 0/0", winner, game_active); end
      total++; if (aliens_left !== 6'd0) begin bad++; $display("FAIL win_idle_keep: got %0d expected 0", aliens_left); end
   endtask

   task automatic test_both_final();
      press_start();
      alien_hit = 1'b1;
      repeat (23) tick();
      alien_hit = 1'b0;
      player_hit = 1'b1;
      repeat (2) tick();
      player_hit = 1'b0;
      total++; if (aliens_left !== 6'd1 || lives_left !== 2'd1) begin bad++; $display("FAIL both_pre: got aliens=%0d lives=%0d expected 1/1", aliens_left, lives_left); end
      total++; if (score !== exp_score(230)) begin bad++; $display("FAIL both_pre_score: got %0d expected %0d", score, exp_score(230)); end
      alien_hit = 1'b1;
      player_hit = 1'b1;
      tick();
      alien_hit = 1'b0;
      player_hit = 1'b0;
      total++; if (winner !== 1'b1 || game_over !== 1'b0) begin bad++; $display("FAIL both_flags: got winner=%b over=%b expected 1/0", winner, game_over); end
      total++; if (lives_left !== 2'd0 || aliens_left !== 6'd0) begin bad++; $display("FAIL both_counts: got aliens=%0d lives=%0d expected 0/0", aliens_left, lives_left); end
      repeat (HOLD) tick();
      total++; if (winner !== 1'b0) begin bad++; $display("FAIL both_idle: got winner=%b expected 0", winner); end
   endtask

   task automatic test_lose();
      press_start();
      player_hit = 1'b1;
      tick();
      player_hit = 1'b0;
      total++; if (lives_left !== 2'd2 || game_active !== 1'b1) begin bad++; $display("FAIL lose_first: got lives=%0d active=%b expected 2/1", lives_left, game_active); end
      player_hit = 1'b1;
      repeat (2) tick();
      player_hit = 1'b0;
      total++; if (game_over !== 1'b1 || winner !== 1'b0 || game_active !== 1'b0) begin bad++; $display("FAIL lose_flags: got over=%b win=%b active=%b expected 1/0/0", game_over, winner, game_active); end
      total++; if (lives_left !== 2'd0) begin bad++; $display("FAIL lose_lives: got %0d expected 0", lives_left); end
      // junk during the hold: hits and start presses must be ignored
      for (int i = 0; i < 6; i++) begin
         alien_hit = 1'b1;
         start_btn = (i % 2 == 0);
         tick();
      end
      alien_hit = 1'b0;
      start_btn = 1'b0;
      total++; if (aliens_left !== 6'd24 || score !== 16'd0) begin bad++; $display("FAIL lose_frozen: got aliens=%0d score=%0d expected 24/0", aliens_left, score); end
      total++; if (game_over !== 1'b1 || game_active !== 1'b0) begin bad++; $display("FAIL lose_held: got over=%b active=%b expected 1/0", game_over, game_active); end
      repeat (HOLD - 6) tick();
      total++; if (game_over !== 1'b0 || game_active !== 1'b0) begin bad++; $display("FAIL lose_idle: got over=%b active=%b expected 0/0", game_over, game_active); end
      total++; if (lives_left !== 2'd0) begin bad++; $display("FAIL lose_idle_keep: got %0d expected 0", lives_left); end
   endtask

   task automatic test_start_held_reset();
      start_btn = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      total++; if (game_active !== 1'b0) begin bad++; $display("FAIL held_start_idle: got %b expected 0", game_active); end
      start_btn = 1'b0;
      tick();
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      total++; if (game_active !== 1'b1 || aliens_left !== 6'd24) begin bad++; $display("FAIL held_start_play: got active=%b aliens=%0d expected 1/24", game_active, aliens_left); end
   endtask

   task automatic test_rst_mid_win();
      alien_hit = 1'b1;
      repeat (24) tick();
      alien_hit = 1'b0;
      repeat (3) tick();
      total++; if (winner !== 1'b1) begin bad++; $display("FAIL midwin_pre: got %b expected 1", winner); end
      rst = 1'b1;
      #1;
      total++; if ({game_active, winner, game_over} !== 3'b000) begin bad++; $display("FAIL midwin_rst_flags: got %b expected 000", {game_active, winner, game_over}); end
      total++; if ({aliens_left, lives_left, score} !== 24'h0) begin bad++; $display("FAIL midwin_rst_counts: got %h expected 000000", {aliens_left, lives_left, score}); end
      tick();
      rst = 1'b0;
      repeat (2) tick();
      total++; if (winner !== 1'b0 || game_active !== 1'b0) begin bad++; $display("FAIL midwin_after: got winner=%b active=%b expected 0/0", winner, game_active); end
   endtask

   initial begin
      test_reset();
      test_win();
      test_both_final();
      test_lose();
      test_start_held_reset();
      test_rst_mid_win();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
